mul_frame_accumulator: RTL and testbench

- Downstream consumer of the 2-stage 4x4 add-tree multiplier. It takes the 8-bit product stream with a valid/ready handshake and sums FRAME_LEN accepted products into one frame result.
- The result is presented on a valid/ready output port and held until the sink takes it.
- Used as the dot-product / MAC back end ahead of the result RAM or the FIFO write side.

---
 rtl/mul_frame_accumulator.sv | 113 +++++++++++
 tb/tb_mul_frame_accumulator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_frame_accumulator.sv
// Frame accumulator for the add-tree multiplier product stream: sums FRAME_LEN
// accepted products and holds the sum on a valid/ready port until the sink takes it.
module mul_frame_accumulator #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              frame_clr,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              acc_ovf,
  output logic [CNT_W-1:0]  sample_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   acc_out_nxt;
  logic               ovf;
  logic               ovf_nxt;
  logic               acc_ovf_nxt;
  logic               acc_valid_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [ACC_W:0]     sum;
  logic               accept;
  logic               last;

  // Ready depends on the state register only, so it never loops back through the source.
  assign prod_ready = (state == ACCUM);
  assign accept     = prod_valid & prod_ready;
  assign last       = (sample_cnt == CNT_W'(FRAME_LEN - 1));
  assign sum        = {1'b0, acc} + (ACC_W + 1)'(prod_in);

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    ovf_nxt       = ovf;
    cnt_nxt       = sample_cnt;
    acc_out_nxt   = acc_out;
    acc_ovf_nxt   = acc_ovf;
    acc_valid_nxt = acc_valid;

    if (frame_clr) begin
      // Abort: drop any in-flight product and any pending result; acc_out/acc_ovf are left stale.
      state_nxt     = ACCUM;
      acc_nxt       = '0;
      ovf_nxt       = 1'b0;
      cnt_nxt       = '0;
      acc_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              acc_out_nxt   = sum[ACC_W-1:0];
              acc_ovf_nxt   = ovf | sum[ACC_W];
              acc_valid_nxt = 1'b1;
              state_nxt     = HOLD;
              acc_nxt       = '0;
              ovf_nxt       = 1'b0;
              cnt_nxt       = '0;
            end else begin
              acc_nxt = sum[ACC_W-1:0];
              ovf_nxt = ovf | sum[ACC_W];
              cnt_nxt = sample_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (acc_valid && acc_ready) begin
            acc_valid_nxt = 1'b0;
            state_nxt     = ACCUM;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= '0;
      ovf        <= 1'b0;
      sample_cnt <= '0;
      acc_out    <= '0;
      acc_ovf    <= 1'b0;
      acc_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      ovf        <= ovf_nxt;
      sample_cnt <= cnt_nxt;
      acc_out    <= acc_out_nxt;
      acc_ovf    <= acc_ovf_nxt;
      acc_valid  <= acc_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mul_frame_accumulator.sv
// Directed bench for mul_frame_accumulator: default 12-bit instance plus an
// 8-bit accumulator instance sharing the same stimulus for wrap checks.
module tb_mul_frame_accumulator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  prod_in;
  logic        prod_valid;
  logic        frame_clr;
  logic        acc_ready;

  logic        prod_ready;
  logic [11:0] acc_out;
  logic        acc_valid;
  logic        acc_ovf;
  logic [7:0]  sample_cnt;

  logic        prod_ready8;
  logic [7:0]  acc_out8;
  logic        acc_valid8;
  logic        acc_ovf8;
  logic [7:0]  sample_cnt8;

  int unsigned vectors;
  int unsigned miscompares;

  mul_frame_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .frame_clr  (frame_clr),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_ovf    (acc_ovf),
    .sample_cnt (sample_cnt)
  );

  mul_frame_accumulator #(
    .DATA_W    (8),
    .FRAME_LEN (4),
    .ACC_W     (8),
    .CNT_W     (8)
  ) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready8),
    .frame_clr  (frame_clr),
    .acc_out    (acc_out8),
    .acc_valid  (acc_valid8),
    .acc_ready  (acc_ready),
    .acc_ovf    (acc_ovf8),
    .sample_cnt (sample_cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] v);
    prod_valid = 1'b1;
    prod_in    = v;
    chk("feed_ready", {31'd0, prod_ready}, 32'd1);
    tick();
    prod_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    prod_in     = '0;
    prod_valid  = 1'b0;
    frame_clr   = 1'b0;
    acc_ready   = 1'b1;

    // Reset state
    #2;
    chk("rst_valid", {31'd0, acc_valid}, 32'd0);
    chk("rst_out", {20'd0, acc_out}, 32'd0);
    chk("rst_ovf", {31'd0, acc_ovf}, 32'd0);
    chk("rst_cnt", {24'd0, sample_cnt}, 32'd0);
    chk("rst_ready", {31'd0, prod_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic frame 1,4,9,16
    feed(8'd1);
    feed(8'd4);
    feed(8'd9);
    feed(8'd16);
    chk("basic_out", {20'd0, acc_out}, 32'd30);
    chk("basic_valid", {31'd0, acc_valid}, 32'd1);
    chk("basic_ovf", {31'd0, acc_ovf}, 32'd0);
    chk("basic_ready_hold", {31'd0, prod_ready}, 32'd0);
    tick();
    chk("basic_taken", {31'd0, acc_valid}, 32'd0);
    chk("basic_ready_again", {31'd0, prod_ready}, 32'd1);

    // Gapped input 2,0,7,5
    feed(8'd2);
    chk("gap_cnt1", {24'd0, sample_cnt}, 32'd1);
    idle(2);
    chk("gap_cnt1_hold", {24'd0, sample_cnt}, 32'd1);
    feed(8'd0);
    chk("gap_cnt2", {24'd0, sample_cnt}, 32'd2);
    idle(2);
    chk("gap_cnt2_hold", {24'd0, sample_cnt}, 32'd2);
    feed(8'd7);
    chk("gap_cnt3", {24'd0, sample_cnt}, 32'd3);
    idle(2);
    chk("gap_cnt3_hold", {24'd0, sample_cnt}, 32'd3);
    chk("gap_not_yet", {31'd0, acc_valid}, 32'd0);
    feed(8'd5);
    chk("gap_out", {20'd0, acc_out}, 32'd14);
    chk("gap_valid", {31'd0, acc_valid}, 32'd1);
    tick();
    chk("gap_taken", {31'd0, acc_valid}, 32'd0);

    // Backpressure: 10 x4, sink stalled, product held during HOLD
    acc_ready = 1'b0;
    feed(8'd10);
    feed(8'd10);
    feed(8'd10);
    feed(8'd10);
    prod_valid = 1'b1;
    prod_in    = 8'd99;
    for (int unsigned i = 0; i < 5; i++) begin
      chk("bp_out", {20'd0, acc_out}, 32'd40);
      chk("bp_valid", {31'd0, acc_valid}, 32'd1);
      chk("bp_ready", {31'd0, prod_ready}, 32'd0);
      chk("bp_cnt", {24'd0, sample_cnt}, 32'd0);
      tick();
    end
    acc_ready = 1'b1;
    chk("bp_still_valid", {31'd0, acc_valid}, 32'd1);
    tick();
    chk("bp_taken", {31'd0, acc_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, prod_ready}, 32'd1);
    chk("bp_cnt_before", {24'd0, sample_cnt}, 32'd0);
    tick();
    prod_valid = 1'b0;
    chk("bp_held_accepted", {24'd0, sample_cnt}, 32'd1);
    feed(8'd1);
    feed(8'd1);
    feed(8'd1);
    chk("bp_frame2_out", {20'd0, acc_out}, 32'd102);
    chk("bp_frame2_valid", {31'd0, acc_valid}, 32'd1);
    tick();

    // Overflow on the 8-bit instance
    feed(8'd255);
    feed(8'd255);
    feed(8'd255);
    feed(8'd255);
    chk("ovf8_out", {24'd0, acc_out8}, 32'd252);
    chk("ovf8_flag", {31'd0, acc_ovf8}, 32'd1);
    chk("ovf12_out", {20'd0, acc_out}, 32'd1020);
    chk("ovf12_flag", {31'd0, acc_ovf}, 32'd0);
    tick();
    feed(8'd1);
    feed(8'd1);
    feed(8'd1);
    feed(8'd1);
    chk("ovf8_next_out", {24'd0, acc_out8}, 32'd4);
    chk("ovf8_next_flag", {31'd0, acc_ovf8}, 32'd0);
    tick();

    // frame_clr case 1: mid-frame abort drops concurrent product
    feed(8'd3);
    feed(8'd3);
    chk("clr_cnt_before", {24'd0, sample_cnt}, 32'd2);
    frame_clr  = 1'b1;
    prod_valid = 1'b1;
    prod_in    = 8'd3;
    tick();
    frame_clr  = 1'b0;
    prod_valid = 1'b0;
    chk("clr_cnt", {24'd0, sample_cnt}, 32'd0);
    chk("clr_valid", {31'd0, acc_valid}, 32'd0);
    feed(8'd1);
    feed(8'd2);
    feed(8'd3);
    feed(8'd4);
    chk("clr_out", {20'd0, acc_out}, 32'd10);
    chk("clr_out_valid", {31'd0, acc_valid}, 32'd1);
    tick();

    // frame_clr case 2: pending result discarded even with acc_ready=1
    acc_ready = 1'b0;
    feed(8'd5);
    feed(8'd5);
    feed(8'd5);
    feed(8'd5);
    chk("clr2_pending", {31'd0, acc_valid}, 32'd1);
    chk("clr2_pending_out", {20'd0, acc_out}, 32'd20);
    frame_clr = 1'b1;
    acc_ready = 1'b1;
    tick();
    frame_clr = 1'b0;
    chk("clr2_valid", {31'd0, acc_valid}, 32'd0);
    chk("clr2_ready", {31'd0, prod_ready}, 32'd1);
    chk("clr2_out_kept", {20'd0, acc_out}, 32'd20);
    feed(8'd1);
    feed(8'd1);
    feed(8'd1);
    feed(8'd1);
    chk("clr2_next_out", {20'd0, acc_out}, 32'd4);
    tick();

    // Async reset mid-frame
    feed(8'd1);
    feed(8'd2);
    feed(8'd3);
    chk("ar1_cnt_before", {24'd0, sample_cnt}, 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar1_cnt", {24'd0, sample_cnt}, 32'd0);
    chk("ar1_out", {20'd0, acc_out}, 32'd0);
    chk("ar1_valid", {31'd0, acc_valid}, 32'd0);
    chk("ar1_ovf", {31'd0, acc_ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Async reset in HOLD with an overflowed result on the 8-bit instance
    acc_ready = 1'b0;
    feed(8'd255);
    feed(8'd255);
    feed(8'd255);
    feed(8'd255);
    chk("ar2_pending8", {31'd0, acc_ovf8}, 32'd1);
    chk("ar2_pending", {31'd0, acc_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar2_valid", {31'd0, acc_valid}, 32'd0);
    chk("ar2_out", {20'd0, acc_out}, 32'd0);
    chk("ar2_ovf8", {31'd0, acc_ovf8}, 32'd0);
    chk("ar2_out8", {24'd0, acc_out8}, 32'd0);
    chk("ar2_cnt", {24'd0, sample_cnt}, 32'd0);
    chk("ar2_ready", {31'd0, prod_ready}, 32'd1);
    tick();
    rst_n     = 1'b1;
    acc_ready = 1'b1;
    tick();
    feed(8'd5);
    feed(8'd6);
    feed(8'd7);
    feed(8'd8);
    chk("ar_after_out", {20'd0, acc_out}, 32'd26);
    chk("ar_after_valid", {31'd0, acc_valid}, 32'd1);
    chk("ar_after_ovf", {31'd0, acc_ovf}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
